// File: rtl/dv_status_monitor.sv
// dv_status_monitor: per-lane start/alive/pass-fail status checkpoint monitor with watchdog.
//
// Ports:
//   clock        sole clock, all state on the rising edge
//   resetb       asynchronous active-low reset
//   enable       1 = sample status and advance counters, 0 = freeze
//   clear        synchronous restart of every lane, overrides enable
//   status       lane i code in [i*CODE_W +: CODE_W]
//   lane_state   lane i FSM state in [i*3 +: 3]
//   lane_code    code latched on entry to UNKNOWN, otherwise 0
//   lane_timeout 1 = lane watchdog expired
//   done         registered AND of all lanes terminal
//   pass         registered AND of all lanes in PASS
//
// Optional build macro: DV_STATUS_MONITOR_DEGLITCH_EN (act on a code only
// after it is seen on two consecutive enabled edges).
module dv_status_monitor #(
    parameter int CHANNELS   = 2,
    parameter int CODE_W     = 2,
    parameter int TIMEOUT_W  = 20,
    parameter int TIMEOUT    = 500000,
    parameter int CODE_FAIL  = 0,
    parameter int CODE_START = 1,
    parameter int CODE_ALIVE = 2,
    parameter int CODE_PASS  = 3
) (
    input  logic                       clock,
    input  logic                       resetb,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [CHANNELS*CODE_W-1:0] status,
    output logic [CHANNELS*3-1:0]      lane_state,
    output logic [CHANNELS*CODE_W-1:0] lane_code,
    output logic [CHANNELS-1:0]        lane_timeout,
    output logic                       done,
    output logic                       pass
);
    typedef enum logic [2:0] {
        WAIT_START = 3'd0,
        WAIT_ALIVE = 3'd1,
        RUNNING    = 3'd2,
        ST_PASS    = 3'd3,
        ST_FAIL    = 3'd4,
        UNKNOWN    = 3'd5,
        ST_TIMEOUT = 3'd6
    } state_t;

    localparam logic [CODE_W-1:0] C_FAIL  = CODE_W'(CODE_FAIL);
    localparam logic [CODE_W-1:0] C_START = CODE_W'(CODE_START);
    localparam logic [CODE_W-1:0] C_ALIVE = CODE_W'(CODE_ALIVE);
    localparam logic [CODE_W-1:0] C_PASS  = CODE_W'(CODE_PASS);

    logic [CHANNELS-1:0] term;
    logic [CHANNELS-1:0] passed;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        state_t               st;
        state_t               nxt;
        logic [TIMEOUT_W-1:0] cnt;
        logic [CODE_W-1:0]    code;
        logic [CODE_W-1:0]    cap;
        logic                 valid;
        logic                 expire;

        assign code = status[i*CODE_W +: CODE_W];

`ifdef DV_STATUS_MONITOR_DEGLITCH_EN
        logic [CODE_W-1:0] prev;
        logic              prev_ok;
        // prev_ok blocks the first sample after reset/clear from ever matching
        always_ff @(posedge clock or negedge resetb) begin
            if (!resetb) begin
                prev    <= '0;
                prev_ok <= 1'b0;
            end else if (clear) begin
                prev    <= '0;
                prev_ok <= 1'b0;
            end else if (enable) begin
                prev    <= code;
                prev_ok <= 1'b1;
            end
        end
        assign valid = prev_ok && (prev == code);
`else
        assign valid = 1'b1;
`endif

        always_comb begin
            nxt = st;
            if (valid)
                case (st)
                    WAIT_START: nxt = (code == C_START) ? WAIT_ALIVE : st;
                    WAIT_ALIVE: nxt = (code == C_ALIVE) ? RUNNING : st;
                    RUNNING:    nxt = (code == C_ALIVE) ? RUNNING :
                                      (code == C_PASS)  ? ST_PASS :
                                      (code == C_FAIL)  ? ST_FAIL : UNKNOWN;
                    default:    nxt = st;
                endcase
        end

        // A TIMEOUT of 0 never matches, which disables the watchdog
        assign expire = (TIMEOUT != 0) && (cnt == TIMEOUT_W'(TIMEOUT - 1));

        // Terminal lanes stop updating, so the counter saturates there
        always_ff @(posedge clock or negedge resetb) begin
            if (!resetb) begin
                st  <= WAIT_START;
                cnt <= '0;
                cap <= '0;
            end else if (clear) begin
                st  <= WAIT_START;
                cnt <= '0;
                cap <= '0;
            end else if (enable && !term[i]) begin
                st  <= (expire && nxt < ST_PASS) ? ST_TIMEOUT : nxt;
                cnt <= cnt + 1'b1;
                if (nxt == UNKNOWN)
                    cap <= code;
            end
        end

        assign term[i]                        = st >= ST_PASS;
        assign passed[i]                      = st == ST_PASS;
        assign lane_state[i*3 +: 3]           = st;
        assign lane_code[i*CODE_W +: CODE_W]  = cap;
        assign lane_timeout[i]                = st == ST_TIMEOUT;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (clear) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (enable) begin
            done <= &term;
            pass <= &passed;
        end
    end
endmodule
